// File: rtl/ring_fifo_if.sv
// ring_fifo_if: producer/consumer bundle for ring_fifo.
// The master modport is the user side, which drives push/pop/data_in.
// The slave modport is the FIFO side, which returns data and status.
interface ring_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, data_in, pop,
    input  data_out, data_valid, count, empty, full,
    input  almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, data_valid, count, empty, full,
    output almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/ring_fifo.sv
// ring_fifo: single-clock circular FIFO with an exact occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow pulses.
// Compile-time option RING_FIFO_OVERWRITE_EN: when it is defined, a push while
// full with no pop overwrites the oldest entry. When it is undefined, that push
// is dropped. Both builds pulse overflow for such a push.
module ring_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic        clk,
  input  logic        reset,
  ring_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  // Storage is deliberately not reset. Reset only clears the pointers and count.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              almost_full_q, almost_full_d;

  logic              is_full_s;
  logic              is_empty_s;
  logic              pop_ok_s;
  logic              inc_s;
  logic              ovw_s;
  logic              mem_we_s;

  // Next-state decode: every decision uses the registered count at the edge.
  always_comb begin
    is_full_s   = (count_q == DEPTH_C);
    is_empty_s  = (count_q == {CNT_W{1'b0}});
    pop_ok_s    = bus.pop && !is_empty_s;
    underflow_d = bus.pop && is_empty_s;
    overflow_d  = bus.push && is_full_s && !bus.pop;
    // A push that adds an entry: room is free, or a same-cycle pop frees a slot.
    inc_s       = bus.push && (!is_full_s || bus.pop);
`ifdef RING_FIFO_OVERWRITE_EN
    ovw_s       = overflow_d;
`else
    ovw_s       = 1'b0;
`endif
    mem_we_s    = (inc_s || ovw_s) && !reset;

    if (inc_s || ovw_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s || ovw_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // The read takes the value before any same-cycle write to the same slot.
    if (pop_ok_s) begin
      data_out_d = mem_q[rd_ptr_q];
    end else begin
      data_out_d = data_out_q;
    end
    data_valid_d = pop_ok_s;

    // An overwrite leaves the count unchanged because it is neither an add nor a remove.
    case ({inc_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d        = (count_d == {CNT_W{1'b0}});
    full_d         = (count_d == DEPTH_C);
    almost_empty_d = (count_d <= AE_C);
    almost_full_d  = (count_d >= AF_C);
  end

  // Control and status registers; reset takes priority over push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      data_out_q     <= {DATA_W{1'b0}};
      data_valid_q   <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
    end
  end

  // Storage write port; the write enable is already gated off during reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
